// File: rtl/y_argmax_unloader.sv
// Captures a final N-word output frame, finds the signed argmax with one
// compare per cycle, then streams the words over valid/ready.
module y_argmax_unloader #(
  parameter int N        = 8,
  parameter int n        = 32,
  parameter int intbits  = 12,
  parameter int fracbits = 20,
  parameter int IW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N*n-1:0]  Y,
  input  logic            y_valid,
  output logic [n-1:0]    out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic [IW-1:0]   class_idx,
  output logic            class_valid,
  output logic [7:0]      drop_cnt
);

  if (intbits + fracbits != n) begin : g_fmt_chk
    $error("intbits + fracbits must equal n");
  end

  typedef enum logic [1:0] {IDLE, SCAN, SEND} state_t;

  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t        state;
  logic [n-1:0]  buf_q [N];
  logic [n-1:0]  best_val;
  logic [IW-1:0] best_idx;
  logic [IW-1:0] scan_idx;
  logic [IW-1:0] send_idx;

  logic          hs;
  logic          fin;
  logic          accept;
  logic          drop;
  logic          better;
  logic [n-1:0]  scan_word;

  // Handshake, frame acceptance and the running compare.
  always_comb begin
    hs        = (state == SEND) & out_ready;
    fin       = hs & out_last;
    accept    = y_valid & ((state == IDLE) | fin);
    drop      = y_valid & ~accept;
    scan_word = buf_q[scan_idx];
    better    = $signed(scan_word) > $signed(best_val);
  end

  // Frame buffer: contents are don't-care across reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < N; i++) begin
        buf_q[i] <= Y[i*n +: n];
      end
    end
  end

  // Control FSM with registered stream and class outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      best_val    <= '0;
      best_idx    <= '0;
      scan_idx    <= '0;
      send_idx    <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      class_idx   <= '0;
      class_valid <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      class_valid <= 1'b0;
      if (drop && drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
      unique case (state)
        IDLE: begin
        end
        SCAN: begin
          if (better) begin
            best_val <= scan_word;
            best_idx <= scan_idx;
          end
          scan_idx <= scan_idx + 1'b1;
          if (scan_idx == LAST) begin
            state       <= SEND;
            class_idx   <= better ? scan_idx : best_idx;
            class_valid <= 1'b1;
            out_valid   <= 1'b1;
            out_data    <= buf_q[0];
            out_last    <= (N == 1);
            send_idx    <= '0;
          end
        end
        SEND: begin
          if (hs) begin
            if (out_last) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              send_idx <= send_idx + 1'b1;
              out_data <= buf_q[send_idx + 1'b1];
              out_last <= ((send_idx + 1'b1) == LAST);
            end
          end
        end
        default: state <= IDLE;
      endcase
      // A new frame (from IDLE or on the final handshake) wins.
      if (accept) begin
        best_val <= Y[n-1:0];
        best_idx <= '0;
        scan_idx <= IW'(1);
        if (N == 1) begin
          state       <= SEND;
          class_idx   <= '0;
          class_valid <= 1'b1;
          out_valid   <= 1'b1;
          out_data    <= Y[n-1:0];
          out_last    <= 1'b1;
          send_idx    <= '0;
        end else begin
          state <= SCAN;
        end
      end
    end
  end

endmodule

// File: tb/tb_y_argmax_unloader.sv
// Scoreboard bench for y_argmax_unloader: stimulus pushes expected
// words/classes, a negedge monitor pops and compares.
module tb_y_argmax_unloader;

  localparam int N  = 8;
  localparam int W  = 32;
  localparam int IW = 3;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N*W-1:0] Y = '0;
  logic           y_valid = 1'b0;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic           out_last;
  logic [IW-1:0]  class_idx;
  logic           class_valid;
  logic [7:0]     drop_cnt;

  y_argmax_unloader #(.N(N), .n(W), .intbits(12), .fracbits(20)) dut (
    .clk(clk), .reset(reset), .Y(Y), .y_valid(y_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .class_idx(class_idx),
    .class_valid(class_valid), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] d; logic l; int c; } wexp_t;
  typedef struct { int idx; int c; } cexp_t;

  wexp_t wq[$];
  cexp_t cq[$];

  int cyc = 0;
  int tests = 0;
  int failed = 0;
  int hs_count = 0;
  int word_no = 0;
  logic [W-1:0] fw [N];

  logic         hold_chk = 1'b0;
  logic [W-1:0] hold_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: class pulses, accepted words, and stability under stall.
  always @(negedge clk) begin
    if (hold_chk && reset) begin
      tests++;
      if (!out_valid || out_data !== hold_data) begin
        failed++;
        $display("FAIL hold: valid=%b data=%h, required valid=1 data=%h",
                 out_valid, out_data, hold_data);
      end
    end
    hold_chk  = out_valid && !out_ready && reset;
    hold_data = out_data;
    if (class_valid) begin
      tests++;
      if (cq.size() == 0) begin
        failed++;
        $display("FAIL class: unexpected pulse idx=%0d at cyc %0d",
                 class_idx, cyc);
      end else begin
        cexp_t e;
        e = cq.pop_front();
        if (class_idx !== IW'(e.idx) || (e.c >= 0 && cyc != e.c)) begin
          failed++;
          $display("FAIL class: idx=%0d cyc=%0d, required idx=%0d cyc=%0d",
                   class_idx, cyc, e.idx, e.c);
        end
      end
    end
    if (out_valid && out_ready) begin
      hs_count++;
      tests++;
      if (wq.size() == 0) begin
        failed++;
        $display("FAIL word: unexpected %h at cyc %0d", out_data, cyc);
      end else begin
        wexp_t e;
        e = wq.pop_front();
        if (out_data !== e.d || out_last !== e.l ||
            (e.c >= 0 && cyc != e.c)) begin
          failed++;
          $display("FAIL word%0d: data=%h last=%b cyc=%0d, required %h %b %0d",
                   word_no, out_data, out_last, cyc, e.d, e.l, e.c);
        end
      end
      word_no = out_last ? 0 : word_no + 1;
    end
  end

  task automatic start_frame(input int cls, input bit timed);
    int c0;
    c0 = cyc;
    for (int i = 0; i < N; i++) Y[i*W +: W] = fw[i];
    y_valid = 1'b1;
    cq.push_back('{idx: cls, c: timed ? c0 + N : -1});
    for (int i = 0; i < N; i++) begin
      wq.push_back('{d: fw[i], l: (i == N - 1),
                     c: timed ? c0 + N + i : -1});
    end
    @(posedge clk); #1;
    y_valid = 1'b0;
  endtask

  task automatic wait_drain(input int maxc, input string nm);
    int k;
    k = 0;
    while ((wq.size() != 0 || cq.size() != 0) && k < maxc) begin
      @(posedge clk); #1;
      k++;
    end
    tests++;
    if (wq.size() != 0 || cq.size() != 0) begin
      failed++;
      $display("FAIL %s: timeout, %0d words %0d classes pending, required 0",
               nm, wq.size(), cq.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check8(input string nm, input logic [7:0] act,
                        input logic [7:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  initial begin
    int base;
    int k;
    // 1: reset with random inputs
    #2 reset = 1'b0;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) Y[i*W +: W] = $urandom;
      y_valid   = 1'($urandom);
      out_ready = 1'($urandom);
      @(posedge clk); #1;
    end
    tests++;
    if (out_data !== '0 || out_valid !== 1'b0 || out_last !== 1'b0 ||
        class_idx !== '0 || class_valid !== 1'b0 || drop_cnt !== '0) begin
      failed++;
      $display("FAIL reset: data=%h v=%b l=%b idx=%0d cv=%b drop=%0d, required all 0",
               out_data, out_valid, out_last, class_idx, class_valid, drop_cnt);
    end
    y_valid   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    for (int r = 0; r < 20; r++) begin
      tests++;
      if (out_valid !== 1'b0) begin
        failed++;
        $display("FAIL idle_valid: got %b at cycle %0d, required 0",
                 out_valid, r);
      end
      @(posedge clk); #1;
    end

    // 2: ascending, max at 5
    for (int i = 0; i < N; i++) fw[i] = i * 32'h0010_0000;
    fw[5] = 32'h7FF0_0000;
    start_frame(5, 1'b1);
    wait_drain(40, "ascending");

    // 3: signed compare
    for (int i = 0; i < N; i++) fw[i] = 32'hFFE0_0000;
    fw[3] = 32'hFFF8_0000;
    start_frame(3, 1'b1);
    wait_drain(40, "signed");

    // 4: ties keep lowest index
    for (int i = 0; i < N; i++) fw[i] = 32'h0010_0000;
    fw[2] = 32'h0030_0000;
    fw[6] = 32'h0030_0000;
    start_frame(2, 1'b1);
    wait_drain(40, "ties");

    // 5a: backpressure 1010...
    fw = '{32'd5, 32'hFFFF_FFFD, 32'd9, 32'd9, 32'd1, 32'd0, 32'd8, 32'd2};
    base = hs_count;
    start_frame(2, 1'b0);
    k = 0;
    while (wq.size() != 0 && k < 60) begin
      out_ready = ~out_ready;
      @(posedge clk); #1;
      k++;
    end
    out_ready = 1'b1;
    wait_drain(40, "backpressure");
    tests++;
    if (hs_count - base != N) begin
      failed++;
      $display("FAIL handshakes: got %0d, required %0d", hs_count - base, N);
    end

    // 5b: y_valid during SCAN is dropped
    for (int i = 0; i < N; i++) fw[i] = 32'h8000_0000 + i;
    start_frame(7, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) Y[i*W +: W] = 32'h7FFF_FFFF;
    y_valid = 1'b1;
    @(posedge clk); #1;
    y_valid = 1'b0;
    wait_drain(40, "drop_scan");
    check8("drop_cnt_scan", drop_cnt, 8'd1);

    // 5c: y_valid on the final handshake is accepted
    fw[0] = 32'h7FFF_FFFF;
    for (int i = 1; i < N; i++) fw[i] = 32'h0;
    start_frame(0, 1'b1);
    repeat (14) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) fw[i] = 32'h1234_5678;
    start_frame(0, 1'b1);
    wait_drain(60, "back_to_back");
    check8("drop_cnt_b2b", drop_cnt, 8'd1);

    // 6: reset mid-SEND after 3 words
    for (int i = 0; i < N; i++) fw[i] = 32'h0001_0000 * (i + 1);
    base = hs_count;
    start_frame(7, 1'b0);
    k = 0;
    while (hs_count < base + 3 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    tests++;
    if (hs_count < base + 3) begin
      failed++;
      $display("FAIL mid_send: %0d words seen, required 3", hs_count - base);
    end
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    tests++;
    if (out_data !== '0 || out_valid !== 1'b0 || out_last !== 1'b0 ||
        class_idx !== '0 || class_valid !== 1'b0 || drop_cnt !== '0) begin
      failed++;
      $display("FAIL reset_mid: data=%h v=%b l=%b idx=%0d cv=%b drop=%0d, required all 0",
               out_data, out_valid, out_last, class_idx, class_valid, drop_cnt);
    end
    wq.delete();
    cq.delete();
    word_no = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) fw[i] = 32'hFFF0_0000;
    fw[4] = 32'h0050_0000;
    start_frame(4, 1'b1);
    wait_drain(40, "after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
